// File: rtl/pipe_addsub_pkg.sv
// Shared constants and the per-stage beat record for the pipelined adder/subtractor.
package pipe_addsub_pkg;

    // Operation encoding on the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 2;

    // Control travelling with a beat; cin is the carry into the next slice.
    typedef struct packed {
        logic valid;
        logic cin;
        logic sat;
    } beat_ctl_t;

endpackage

// File: rtl/addsub_slice.sv
// One carry-chain slice: SLICE_W-bit add with carry in/out and the carry into its msb.
module addsub_slice #(
    parameter int unsigned SLICE_W = 16
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b_eff,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               msb_cin
);

    logic [SLICE_W:0] full;

    // Plain ripple sum with one extra bit for the carry-out.
    always_comb begin
        full = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
    end

    assign sum     = full[SLICE_W-1:0];
    assign cout    = full[SLICE_W];
    // Carry into the msb recovered from the msb sum bit.
    assign msb_cin = a[SLICE_W-1] ^ b_eff[SLICE_W-1] ^ sum[SLICE_W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract, carry chain split into STAGES slices with a global stall.
// Optional saturation: define PIPE_ADDSUB_SAT_EN to add the sat input.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef PIPE_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SW = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic stall;
    logic sat_in;

    // Beat presented to slice k: operands, partial sum so far and control.
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    beat_ctl_t        st_ctl [STAGES];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

`ifdef PIPE_ADDSUB_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert b and feed sub as the first carry-in.
    assign st_a[0]   = a;
    assign st_b[0]   = (sub == OP_SUB) ? ~b : b;
    assign st_sum[0] = '0;
    assign st_ctl[0] = '{valid: in_valid, cin: sub, sat: sat_in};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    s_sum;
        logic             s_cout;
        logic             s_msb_cin;
        logic [WIDTH-1:0] sum_full;

        addsub_slice #(
            .SLICE_W (SW)
        ) u_slice (
            .a       (st_a[k][k*SW +: SW]),
            .b_eff   (st_b[k][k*SW +: SW]),
            .cin     (st_ctl[k].cin),
            .sum     (s_sum),
            .cout    (s_cout),
            .msb_cin (s_msb_cin)
        );

        // Merge this slice's bits into the partial sum carried by the beat.
        always_comb begin
            sum_full              = st_sum[k];
            sum_full[k*SW +: SW]  = s_sum;
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q, a_d;
            logic [WIDTH-1:0] b_q, b_d;
            logic [WIDTH-1:0] sum_q, sum_d;
            beat_ctl_t        ctl_q, ctl_d;
            logic             unused_msb_cin;

            // Only the top slice needs its msb carry-in.
            assign unused_msb_cin = s_msb_cin;

            // Advance the beat and its slice carry unless the output is stalled.
            always_comb begin
                a_d   = a_q;
                b_d   = b_q;
                sum_d = sum_q;
                ctl_d = ctl_q;
                if (!stall) begin
                    a_d       = st_a[k];
                    b_d       = st_b[k];
                    sum_d     = sum_full;
                    ctl_d     = st_ctl[k];
                    ctl_d.cin = s_cout;
                end
            end

            // Stage register between slice k and slice k+1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    ctl_q <= '0;
                end else begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    sum_q <= sum_d;
                    ctl_q <= ctl_d;
                end
            end

            assign st_a[k+1]   = a_q;
            assign st_b[k+1]   = b_q;
            assign st_sum[k+1] = sum_q;
            assign st_ctl[k+1] = ctl_q;
        end else begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] res;

            // Final flags and optional clamp; bubbles load zeros into the output.
            always_comb begin
                ovf = s_cout ^ s_msb_cin;
                res = sum_full;
                if (st_ctl[k].sat && ovf) begin
                    res = st_a[k][WIDTH-1] ? MIN_NEG : MAX_POS;
                end
                out_valid_d = out_valid_q;
                result_d    = result_q;
                carry_d     = carry_q;
                overflow_d  = overflow_q;
                zero_d      = zero_q;
                if (!stall) begin
                    out_valid_d = st_ctl[k].valid;
                    result_d    = st_ctl[k].valid ? res : '0;
                    carry_d     = st_ctl[k].valid && s_cout;
                    overflow_d  = st_ctl[k].valid && ovf;
                    zero_d      = st_ctl[k].valid && (res == '0);
                end
            end

            // Output register; holds while the consumer stalls.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    result_q    <= '0;
                    carry_q     <= 1'b0;
                    overflow_q  <= 1'b0;
                    zero_q      <= 1'b0;
                end else begin
                    out_valid_q <= out_valid_d;
                    result_q    <= result_d;
                    carry_q     <= carry_d;
                    overflow_q  <= overflow_d;
                    zero_q      <= zero_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: four width/depth configurations share one stimulus stream,
// each checked every cycle against a queue-based reference model.
module tb_pipe_addsub;

    localparam int NCFG = 4;

    function automatic int unsigned cfg_w(input int i);
        case (i)
            0:       return 32;
            1:       return 16;
            2:       return 64;
            default: return 16;
        endcase
    endfunction

    function automatic int unsigned cfg_s(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 4;
        endcase
    endfunction

`ifdef PIPE_ADDSUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
        int          rem;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        sub       = 1'b0;
    logic        sat       = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] a         = '0;
    logic [63:0] b         = '0;

    logic [NCFG-1:0] in_rdy, out_vld, cry, ovf, zr;
    logic [63:0]     res [NCFG];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t mq [NCFG][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int unsigned W = cfg_w(g);
        localparam int unsigned S = cfg_s(g);
        logic [W-1:0] r;

        pipe_addsub #(
            .WIDTH  (W),
            .STAGES (S)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
`ifdef PIPE_ADDSUB_SAT_EN
            .sat       (sat),
`endif
            .in_valid  (in_valid),
            .in_ready  (in_rdy[g]),
            .a         (a[W-1:0]),
            .b         (b[W-1:0]),
            .sub       (sub),
            .out_valid (out_vld[g]),
            .out_ready (out_ready),
            .result    (r),
            .carry     (cry[g]),
            .overflow  (ovf[g]),
            .zero      (zr[g])
        );

        assign res[g] = 64'(r);
    end

    // Reference arithmetic on wide signed/unsigned integers.
    function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic subv, input logic satv,
                                   input int unsigned w, input int rem);
        exp_t               e;
        logic [66:0]        mask, ua, ub, sumu, r;
        logic signed [66:0] sa, sb, tr, maxp, minn;
        logic               o;
        mask = (67'd1 << w) - 67'd1;
        ua   = {3'b000, av} & mask;
        ub   = {3'b000, bv} & mask;
        sumu = ua + ub;
        e.c  = subv ? (ua >= ub) : sumu[w];
        sa   = $signed(ua);
        sb   = $signed(ub);
        if (ua[w-1]) sa = sa - $signed(67'd1 << w);
        if (ub[w-1]) sb = sb - $signed(67'd1 << w);
        tr   = subv ? sa - sb : sa + sb;
        maxp = $signed((67'd1 << (w - 1)) - 67'd1);
        minn = -maxp - 67'sd1;
        o    = (tr > maxp) || (tr < minn);
        r    = $unsigned(tr) & mask;
        if (satv && o) r = (tr > 0) ? $unsigned(maxp) : ($unsigned(minn) & mask);
        e.res = r[63:0];
        e.v   = o;
        e.z   = (r == '0);
        e.rem = rem;
        return e;
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cfg%0d actual %h expected %h", nm, i, act, expv);
        end
    endtask

    // Model update: each in-flight beat counts down to the output, frozen on stall.
    initial begin : p_model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NCFG; i++) mq[i].delete();
            end else begin
                for (int i = 0; i < NCFG; i++) begin
                    logic mv;
                    mv = (mq[i].size() != 0) && (mq[i][0].rem == 0);
                    if (!(mv && !out_ready)) begin
                        if (mv) void'(mq[i].pop_front());
                        for (int j = 0; j < mq[i].size(); j++) mq[i][j].rem = mq[i][j].rem - 1;
                        if (in_valid) begin
                            mq[i].push_back(model(a, b, sub, sat && SAT_EN, cfg_w(i),
                                                  int'(cfg_s(i)) - 1));
                        end
                    end
                end
            end
        end
    end

    // Compare DUT against model mid-cycle.
    initial begin : p_cmp
        exp_t m;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                m = model(64'h5, 64'hFFFF_FFFD, 1'b0, 1'b0, 32, 0);
                chk("pin_add_result", 0, m.res, 64'h2);
                chk("pin_add_carry", 0, 64'(m.c), 64'd1);
                chk("pin_add_ovf", 0, 64'(m.v), 64'd0);
                chk("pin_add_zero", 0, 64'(m.z), 64'd0);
                m = model(64'h8000_0000, 64'h1, 1'b1, 1'b0, 32, 0);
                chk("pin_sub_ovf_result", 0, m.res, 64'h7FFF_FFFF);
                chk("pin_sub_ovf_ovf", 0, 64'(m.v), 64'd1);
                chk("pin_sub_ovf_carry", 0, 64'(m.c), 64'd1);
                m = model(64'h8000_0000, 64'h1, 1'b1, 1'b1, 32, 0);
                chk("pin_sat_result", 0, m.res, 64'h8000_0000);
                chk("pin_sat_ovf", 0, 64'(m.v), 64'd1);
                m = model(64'h7, 64'h7, 1'b1, 1'b0, 32, 0);
                chk("pin_zero_result", 0, m.res, 64'h0);
                chk("pin_zero_zero", 0, 64'(m.z), 64'd1);
                chk("pin_zero_carry", 0, 64'(m.c), 64'd1);
                chk("pin_zero_ovf", 0, 64'(m.v), 64'd0);
                m = model(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64, 0);
                chk("pin_w64_result", 2, m.res, 64'h7FFF_FFFF_FFFF_FFFF);
            end
            for (int i = 0; i < NCFG; i++) begin
                if (!rst_n) begin
                    chk("rst_out_valid", i, 64'(out_vld[i]), 64'd0);
                    chk("rst_result", i, res[i], 64'd0);
                    chk("rst_flags", i, {61'd0, cry[i], ovf[i], zr[i]}, 64'd0);
                    chk("rst_in_ready", i, 64'(in_rdy[i]), 64'd1);
                end else begin
                    logic mv;
                    mv = (mq[i].size() != 0) && (mq[i][0].rem == 0);
                    chk("out_valid", i, 64'(out_vld[i]), 64'(mv));
                    chk("in_ready", i, 64'(in_rdy[i]), 64'(!(mv && !out_ready)));
                    if (mv) begin
                        chk("result", i, res[i], mq[i][0].res);
                        chk("carry", i, 64'(cry[i]), 64'(mq[i][0].c));
                        chk("overflow", i, 64'(ovf[i]), 64'(mq[i][0].v));
                        chk("zero", i, 64'(zr[i]), 64'(mq[i][0].z));
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] av, input logic [63:0] bv,
                         input logic sv, input logic stv, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = av;
        b         = bv;
        sub       = sv;
        sat       = stv;
        out_ready = ordy;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin : p_stim
        logic [63:0] ra;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed beats: add with carry-out, overflowing subtract, zero result.
        drive(1'b1, 64'h5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 64'h8000_0000, 64'h1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 64'h8000_0000, 64'h1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 64'h7, 64'h7, 1'b1, 1'b0, 1'b1);
        repeat (6) drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);

        // Continuous stream with consumer stalled on stream cycles 3..6.
        for (int j = 0; j < 12; j++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0,
                  !(j >= 3 && j <= 6));
        end
        repeat (8) drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);

        // Reset with beats in flight.
        drive(1'b1, 64'h11, 64'h22, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 64'h33, 64'h44, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);

        // Random traffic with random back-pressure.
        for (int j = 0; j < 3000; j++) begin
            ra = pick();
            drive($urandom_range(0, 3) != 0, ra,
                  ($urandom_range(0, 7) == 0) ? ra : pick(),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (20) drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 8..64.
REQ-002 Parameter STAGES, default 2, pipeline depth and carry-chain slice count; legal 1..4; WIDTH mod STAGES SHALL be 0.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  operand beat offered.
REQ-006 Port in_ready  output  1  operand beat accepted when in_valid && in_ready at a clk edge.
REQ-007 Port a  input  WIDTH  first operand, two's complement.
REQ-008 Port b  input  WIDTH  second operand, two's complement.
REQ-009 Port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 Port out_valid  output  1  result beat present.
REQ-011 Port out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
REQ-012 Port result  output  WIDTH  sum or difference.
REQ-013 Port carry  output  1  unsigned carry-out; for sub, 1 means no borrow.
REQ-014 Port overflow  output  1  signed overflow of the operation.
REQ-015 Port zero  output  1  result == 0.

Function
REQ-016 Subtraction SHALL be a + ~b + 1, carry-in = sub; no separate negate path.
REQ-017 Carry chain split into STAGES equal slices; slice k computed in pipeline stage k, carry registered between stages; operand bits not yet consumed travel with the beat.
REQ-018 Latency: accepted beat appears on out_valid exactly STAGES cycles later when no stall occurs.
REQ-019 Throughput: one beat per cycle with out_ready held 1.
REQ-020 Stall is global: stall = out_valid && !out_ready; during stall every stage register and valid bit holds.
REQ-021 in_ready = !stall, combinational; in_ready SHALL NOT depend on in_valid.
REQ-022 Bubbles (valid bit 0) advance and are overwritten without stall; empty stages never block input.
REQ-023 overflow = (a_msb == b_eff_msb) && (result_msb != a_msb), b_eff = sub ? ~b : b.
REQ-024 zero, carry, overflow SHALL be registered alongside result and valid only while out_valid = 1; outputs hold stable while out_valid && !out_ready.
REQ-025 Simultaneous out accept and in accept in the same cycle SHALL complete both, no lost or duplicated beat.

Reset
REQ-026 rst_n low SHALL immediately clear all stage valid bits; out_valid = 0, result = 0, carry = 0, overflow = 0, zero = 0.
REQ-027 in_ready SHALL read 1 during and after reset.
REQ-028 Reset mid-operation discards all in-flight beats; no beat emitted after release until a new acceptance.

Configuration
REQ-029 Macro PIPE_ADDSUB_SAT_EN defined: extra input port sat (1 bit, travels with the beat); when sat = 1 and overflow, result clamps to max positive (0x7FFF_FFFF at WIDTH 32) or min negative (0x8000_0000), overflow still reported, zero computed on clamped value.
REQ-030 Macro undefined: no sat port, result always wraps modulo 2^WIDTH.

Structure
REQ-031 Package pipe_addsub_pkg SHALL hold op encoding constants (OP_ADD = 0, OP_SUB = 1), default WIDTH/STAGES constants, and the per-stage beat record typedef.
REQ-032 One sub-module addsub_slice (parameter SLICE_W; inputs a, b_eff, cin; outputs sum, cout, msb carry-in for overflow) instantiated STAGES times.

Verification
REQ-033 WIDTH 32, STAGES 2: a = 5, b = 0xFFFF_FFFD, sub = 0 -> result 2, carry 1, overflow 0, zero 0, out_valid 2 cycles after accept.
REQ-034 a = 0x8000_0000, b = 1, sub = 1 -> result 0x7FFF_FFFF, overflow 1, carry 1; with PIPE_ADDSUB_SAT_EN and sat = 1 -> result 0x8000_0000, overflow 1.
REQ-035 a = 7, b = 7, sub = 1 -> result 0, zero 1, carry 1, overflow 0.
REQ-036 Stream 8 beats, out_ready low for cycles 3..6 -> in_ready low exactly while out_valid && !out_ready, outputs frozen, all 8 results in order, none lost or duplicated.
REQ-037 Assert rst_n low with 2 beats in flight -> out_valid 0 immediately, no result emitted after release until a new beat is accepted and STAGES cycles elapse.
REQ-038 Repeat REQ-033 and REQ-036 with STAGES 1 and 4, WIDTH 16 and 64 -> latency equals STAGES, results match reference model.
